// File: rtl/xz_mon_pkg.sv
// xz_mon_pkg: shared FSM states, check modes and the per-bit X/Z classifier
// used by the X/Z integrity monitor and its lane counters.
package xz_mon_pkg;

    typedef enum logic [1:0] {
        XZM_IDLE  = 2'd0,
        XZM_GRACE = 2'd1,
        XZM_ARMED = 2'd2
    } xzm_state_t;

    localparam int MODE_XZ = 0;
    localparam int MODE_X  = 1;
    localparam int MODE_Z  = 2;

    // A bit is known-good unless it is X or Z. Z is split out with a
    // case-equality test only after the bit is already known to be
    // unknown, so a two-valued view of the bit can never count as bad.
    function automatic logic bit_is_bad(
        input logic b,
        input int   mode
    );
        logic unk;
        logic is_z;
        unk  = $isunknown(b);
        is_z = unk && (b === 1'bz);
        case (mode)
            MODE_X:  return unk && !is_z;
            MODE_Z:  return is_z;
            default: return unk;
        endcase
    endfunction

endpackage

// File: rtl/xz_lane_counter.sv
// xz_lane_counter: one monitored channel. Counts bad bits, qualifies a
// violation, keeps a saturating violation counter and a sticky flag.
//   clk, rst_n   clock, async active-low reset
//   armed_i      checking active
//   en_i         channel check enable
//   clr_i        sync clear of counter and flag (wins over a violation)
//   data_i       channel data
//   bad_o        number of illegal bits this cycle
//   viol_o       violation strobe (combinational)
//   cnt_o        registered saturating violation count
//   sticky_o     registered sticky violation flag
module xz_lane_counter
    import xz_mon_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16,
    parameter int MODE  = MODE_XZ,
    parameter int BW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             armed_i,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [BW-1:0]    bad_o,
    output logic             viol_o,
    output logic [CNT_W-1:0] cnt_o,
    output logic             sticky_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             sticky_q;
    logic             sticky_d;

    always_comb begin
        bad_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            bad_o = bad_o + BW'(bit_is_bad(data_i[i], MODE));
        end
    end

    assign viol_o = armed_i && en_i && (bad_o != '0);

    always_comb begin
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        if (clr_i) begin
            cnt_d    = '0;
            sticky_d = 1'b0;
        end else if (viol_o) begin
            sticky_d = 1'b1;
            if (cnt_q != '1) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            sticky_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
        end
    end

    assign cnt_o    = cnt_q;
    assign sticky_o = sticky_q;

endmodule

// File: rtl/xz_integrity_monitor.sv
// xz_integrity_monitor: multi-channel X/Z integrity monitor. Arms after
// init_done plus a grace window, counts violations, captures the first.
//   clk, rst_n   clock, async active-low reset
//   init_done    initialisation finished (level)
//   clr          sync clear of counters, flags and capture
//   ch_en        per-channel check enable
//   data         channel c = data[c*WIDTH +: WIDTH]
//   armed        checking active
//   err_sticky   per-channel sticky flag; err_any = OR of them
//   viol_cnt     per-channel saturating violation counts
//   first_vld/first_ch/first_bits  first violation capture
module xz_integrity_monitor
    import xz_mon_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int NCH       = 4,
    parameter int GRACE     = 2,
    parameter int CNT_W     = 16,
    parameter int MODE      = MODE_XZ,
    parameter int ASSERT_EN = 1,
    localparam int BW       = $clog2(WIDTH + 1),
    localparam int CHW      = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 init_done,
    input  logic                 clr,
    input  logic [NCH-1:0]       ch_en,
    input  logic [NCH*WIDTH-1:0] data,
    output logic                 armed,
    output logic [NCH-1:0]       err_sticky,
    output logic                 err_any,
    output logic [NCH*CNT_W-1:0] viol_cnt,
    output logic                 first_vld,
    output logic [CHW-1:0]       first_ch,
    output logic [BW-1:0]        first_bits
);

    localparam int GW = (GRACE > 0) ? $clog2(GRACE + 1) : 1;

    xzm_state_t      state_q;
    xzm_state_t      state_d;
    logic [GW-1:0]   gcnt_q;
    logic [GW-1:0]   gcnt_d;

    logic [BW-1:0]   bad [NCH];
    logic [NCH-1:0]  viol;

    logic            hit;
    logic [CHW-1:0]  hit_ch;
    logic [BW-1:0]   hit_bits;

    logic            fvld_q;
    logic            fvld_d;
    logic [CHW-1:0]  fch_q;
    logic [CHW-1:0]  fch_d;
    logic [BW-1:0]   fbits_q;
    logic [BW-1:0]   fbits_d;

    always_comb begin
        state_d = state_q;
        gcnt_d  = gcnt_q;
        unique case (state_q)
            XZM_IDLE: begin
                gcnt_d = '0;
                if (init_done) begin
                    state_d = (GRACE == 0) ? XZM_ARMED
                                           : XZM_GRACE;
                end
            end
            XZM_GRACE: begin
                if (!init_done) begin
                    state_d = XZM_IDLE;
                end else if (gcnt_q == GW'(GRACE - 1)) begin
                    state_d = XZM_ARMED;
                end else begin
                    gcnt_d = gcnt_q + GW'(1);
                end
            end
            XZM_ARMED: begin
                if (!init_done) begin
                    state_d = XZM_IDLE;
                end
            end
            default: state_d = XZM_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= XZM_IDLE;
            gcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            gcnt_q  <= gcnt_d;
        end
    end

    assign armed = (state_q == XZM_ARMED);

    for (genvar c = 0; c < NCH; c++) begin : g_lane
        xz_lane_counter #(
            .WIDTH (WIDTH),
            .CNT_W (CNT_W),
            .MODE  (MODE),
            .BW    (BW)
        ) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .armed_i  (armed),
            .en_i     (ch_en[c]),
            .clr_i    (clr),
            .data_i   (data[c*WIDTH +: WIDTH]),
            .bad_o    (bad[c]),
            .viol_o   (viol[c]),
            .cnt_o    (viol_cnt[c*CNT_W +: CNT_W]),
            .sticky_o (err_sticky[c])
        );
    end

    // Scan from the top down so the lowest violating channel wins.
    always_comb begin
        hit      = 1'b0;
        hit_ch   = '0;
        hit_bits = '0;
        for (int c = NCH - 1; c >= 0; c--) begin
            if (viol[c]) begin
                hit      = 1'b1;
                hit_ch   = CHW'(c);
                hit_bits = bad[c];
            end
        end
    end

    always_comb begin
        fvld_d  = fvld_q;
        fch_d   = fch_q;
        fbits_d = fbits_q;
        if (clr) begin
            fvld_d  = 1'b0;
            fch_d   = '0;
            fbits_d = '0;
        end else if (!fvld_q && hit) begin
            fvld_d  = 1'b1;
            fch_d   = hit_ch;
            fbits_d = hit_bits;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fvld_q  <= 1'b0;
            fch_q   <= '0;
            fbits_q <= '0;
        end else begin
            fvld_q  <= fvld_d;
            fch_q   <= fch_d;
            fbits_q <= fbits_d;
        end
    end

    assign first_vld  = fvld_q;
    assign first_ch   = fch_q;
    assign first_bits = fbits_q;
    assign err_any    = |err_sticky;

    if (ASSERT_EN != 0) begin : g_assert
        for (genvar c = 0; c < NCH; c++) begin : ap_no_xz
            a_chk: assert property (
                @(posedge clk) disable iff (!rst_n)
                (armed && ch_en[c]) |-> (bad[c] == '0)
            );
        end
    end

endmodule

// File: tb/tb_xz_integrity_monitor.sv
// tb_xz_integrity_monitor: directed stimulus with a timed scoreboard.
// Instance a: MODE 0, CNT_W 16. Instance b: MODE 1 (X only), CNT_W 2.
module tb_xz_integrity_monitor;

    localparam int W = 32;
    localparam int N = 4;
    localparam logic [63:0] K0 = 64'd0;
    localparam logic [63:0] K1 = 64'd1;

    logic           clk;
    logic           rst_n;
    logic           init_done;
    logic           clr_a;
    logic           clr_b;
    logic [N-1:0]   en_a;
    logic [N-1:0]   en_b;
    logic [N*W-1:0] d_a;
    logic [N*W-1:0] d_b;

    logic           a_armed;
    logic [N-1:0]   a_st;
    logic           a_any;
    logic [N*16-1:0] a_cnt;
    logic           a_fv;
    logic [1:0]     a_fch;
    logic [5:0]     a_fb;

    logic           b_armed;
    logic [N-1:0]   b_st;
    logic           b_any;
    logic [N*2-1:0] b_cnt;
    logic           b_fv;
    logic [1:0]     b_fch;
    logic [5:0]     b_fb;

    xz_integrity_monitor #(
        .WIDTH(W), .NCH(N), .GRACE(2),
        .CNT_W(16), .MODE(0), .ASSERT_EN(0)
    ) u_a (
        .clk(clk), .rst_n(rst_n), .init_done(init_done),
        .clr(clr_a), .ch_en(en_a), .data(d_a),
        .armed(a_armed), .err_sticky(a_st), .err_any(a_any),
        .viol_cnt(a_cnt), .first_vld(a_fv),
        .first_ch(a_fch), .first_bits(a_fb)
    );

    xz_integrity_monitor #(
        .WIDTH(W), .NCH(N), .GRACE(2),
        .CNT_W(2), .MODE(1), .ASSERT_EN(0)
    ) u_b (
        .clk(clk), .rst_n(rst_n), .init_done(init_done),
        .clr(clr_b), .ch_en(en_b), .data(d_b),
        .armed(b_armed), .err_sticky(b_st), .err_any(b_any),
        .viol_cnt(b_cnt), .first_vld(b_fv),
        .first_ch(b_fch), .first_bits(b_fb)
    );

    typedef struct {
        int          cyc;
        int          id;
        logic [63:0] exp;
        string       nm;
    } exp_t;

    exp_t sb[$];
    int   ncount = 0;
    int   checks = 0;
    int   errors = 0;
    bit   fs;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [63:0] act(int id);
        case (id)
            0: return 64'(a_armed);
            1: return 64'(a_st);
            2: return 64'(a_any);
            3: return 64'(a_cnt);
            4: return 64'(a_fv);
            5: return 64'(a_fch);
            6: return 64'(a_fb);
            7: return 64'(b_armed);
            8: return 64'(b_cnt);
            9: return 64'(b_st);
            default: return 64'hdead;
        endcase
    endfunction

    // Values that need a genuinely unknown bit only show up when the
    // simulator can hold X/Z; otherwise the driven bits read as 0.
    function automatic logic [63:0] f(logic [63:0] v);
        return fs ? v : K0;
    endfunction

    task automatic push(int id, logic [63:0] v, string nm);
        exp_t e;
        e.cyc = ncount + 1;
        e.id  = id;
        e.exp = v;
        e.nm  = nm;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    initial begin : mon
        forever begin
            @(negedge clk);
            ncount++;
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].cyc <= ncount) begin
                    logic [63:0] a;
                    a = act(sb[i].id);
                    checks++;
                    if (sb[i].cyc < ncount) begin
                        errors++;
                        $display("FAIL %s: missed cycle %0d",
                                 sb[i].nm, sb[i].cyc);
                    end else if (a !== sb[i].exp) begin
                        errors++;
                        $display("FAIL %s: got %0h want %0h",
                                 sb[i].nm, a, sb[i].exp);
                    end
                    sb.delete(i);
                end
            end
        end
    end

    initial begin : stim
        logic probe;
        probe = 1'bx;
        fs    = $isunknown(probe);

        rst_n     = 1'b0;
        init_done = 1'b0;
        clr_a     = 1'b0;
        clr_b     = 1'b0;
        en_a      = '1;
        en_b      = '1;
        d_a       = 'x;
        d_b       = 'x;
        tick();

        push(0, K0, "rst_armed");
        push(1, K0, "rst_sticky");
        push(2, K0, "rst_any");
        push(3, K0, "rst_cnt");
        push(4, K0, "rst_fvld");
        push(5, K0, "rst_fch");
        push(6, K0, "rst_fbits");
        push(7, K0, "rst_b_armed");
        push(8, K0, "rst_b_cnt");
        tick();

        rst_n = 1'b1;
        d_a   = '0;
        d_b   = '0;
        repeat (2) begin
            push(0, K0, "idle_armed");
            push(3, K0, "idle_cnt");
            tick();
        end

        init_done = 1'b1;
        d_a[7:0]  = 8'hxx;
        push(0, K0, "grace1_armed");
        push(3, K0, "grace1_cnt");
        tick();
        push(0, K0, "grace2_armed");
        push(3, K0, "grace2_cnt");
        tick();
        push(0, K1, "arm_edge3");
        push(7, K1, "b_arm_edge3");
        push(3, K0, "cnt_at_arm");
        tick();
        push(3, f(64'd1), "cnt0_1");
        push(4, f(K1), "first_vld");
        push(5, K0, "first_ch0");
        push(6, f(64'd8), "first_bits8");
        push(1, f(64'h1), "sticky_ch0");
        tick();
        push(3, f(64'd2), "cnt0_2");
        tick();
        push(3, f(64'd3), "cnt0_3");
        push(6, f(64'd8), "first_bits_hold");
        tick();

        clr_a = 1'b1;
        push(3, K0, "clr_cnt");
        push(1, K0, "clr_sticky");
        push(2, K0, "clr_any");
        push(4, K0, "clr_fvld");
        push(6, K0, "clr_fbits");
        tick();

        clr_a   = 1'b0;
        d_a     = '0;
        d_a[37] = 1'bz;
        d_a[96] = 1'bz;
        push(1, f(64'hA), "multi_sticky");
        push(2, f(K1), "multi_any");
        push(4, f(K1), "multi_fvld");
        push(5, f(K1), "multi_fch");
        push(6, f(K1), "multi_fbits");
        push(3, f(64'h0001_0000_0001_0000), "multi_cnt");
        tick();

        en_a = 4'b0111;
        push(3, f(64'h0001_0000_0002_0000), "mask_cnt");
        push(5, f(K1), "mask_fch_hold");
        tick();

        d_a  = '0;
        en_a = '1;
        push(3, f(64'h0001_0000_0002_0000), "clean_hold");
        tick();

        d_b[64 +: 32] = 32'hzzzz_zzzz;
        push(8, K0, "b_z_ignored");
        push(9, K0, "b_z_sticky");
        tick();
        d_b[64 +: 32] = '0;
        d_b[67]       = 1'bx;
        push(8, f(64'h10), "b_x_cnt2");
        push(9, f(64'h4), "b_x_sticky");
        tick();

        d_b      = '0;
        d_b[1:0] = 2'bxx;
        for (int i = 1; i <= 5; i++) begin
            push(8, f(64'h10 | 64'((i < 3) ? i : 3)), "b_sat");
            tick();
        end
        clr_b = 1'b1;
        push(8, K0, "b_clr_cnt");
        push(9, K0, "b_clr_sticky");
        tick();
        clr_b = 1'b0;
        d_b   = '0;
        push(8, K0, "b_after_clr");
        tick();

        init_done = 1'b0;
        push(0, K0, "drop_armed");
        push(7, K0, "drop_b_armed");
        push(3, f(64'h0001_0000_0002_0000), "drop_hold");
        push(1, f(64'hA), "drop_sticky");
        tick();
        d_a[7:0] = 8'hxx;
        push(0, K0, "idle2_armed");
        push(3, f(64'h0001_0000_0002_0000), "idle2_nocnt");
        tick();

        d_a       = '0;
        init_done = 1'b1;
        push(0, K0, "rearm_g1");
        tick();
        push(0, K0, "rearm_g2");
        tick();
        push(0, K1, "rearm");
        tick();

        push(0, K0, "async_armed");
        push(7, K0, "async_b_armed");
        push(1, K0, "async_sticky");
        push(2, K0, "async_any");
        push(3, K0, "async_cnt");
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        push(0, K0, "post_rst_armed");
        tick();
        tick();
        tick();

        foreach (sb[i]) begin
            checks++;
            errors++;
            $display("FAIL %s: never checked", sb[i].nm);
        end
        $display("Result: errors=%0d of %0d checks",
                 errors, checks);
        $finish;
    end

endmodule
